// File: rtl/tt_um_clk_ratio_meter.sv
// Square-wave meter: measures period and high time of sig_in in clk cycles, decodes power-of-two divide ratios,
// and flags lock after repeated matching codes. Outputs are registered, two edges after sig_in is first sampled.
module tt_um_clk_ratio_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [2:0]       ratio_code,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
    logic [2:0]       code_q, code_d;
    logic             valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;

    logic       rise, fall;
    logic [2:0] code_calc;
    logic [3:0] lock_next;

    always_comb begin
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;

        // Clean power-of-two wave: period is 2^n and exactly half of it high.
        code_calc = 3'd0;
        for (int n = 1; n <= 6; n++) begin
            if ((n < CNT_W) && (32'(cnt_q) == (32'd1 << n)) && ((32'(hcnt_q) << 1) == 32'(cnt_q))) begin
                code_calc = 3'(n);
            end
        end

        if (code_calc == 3'd0) begin
            lock_next = 4'd0;
        end else if (code_calc == code_q) begin
            lock_next = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
        end else begin
            lock_next = 4'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        period_d   = period_q;
        high_d     = high_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        locked_d   = locked_q;
        ovf_d      = ovf_q;
        lock_cnt_d = lock_cnt_q;

        case (state_q)
            MEASURE: begin
                if (rise) begin
                    period_d   = cnt_q;
                    high_d     = hcnt_q;
                    code_d     = code_calc;
                    valid_d    = 1'b1;
                    lock_cnt_d = lock_next;
                    locked_d   = (lock_next == LOCK_MAX);
                    ovf_d      = 1'b0;
                    cnt_d      = {{(CNT_W-1){1'b0}}, 1'b1};
                    hcnt_d     = '0;
                end else begin
                    if (fall) begin
                        hcnt_d = cnt_q;
                    end
                    // A rise can no longer land inside a representable period.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d      = CNT_MAX;
                        ovf_d      = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = 4'd0;
                        state_d    = STALL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // IDLE and STALL: next rise is a first edge, nothing reported.
                if (rise) begin
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                    hcnt_d  = '0;
                    state_d = MEASURE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            ovf_q      <= 1'b0;
            lock_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            ovf_q      <= ovf_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign ratio_code = code_q;
    assign valid      = valid_q;
    assign locked     = locked_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_tt_um_clk_ratio_meter.sv
// Bench for tt_um_clk_ratio_meter: directed and random waveforms against an edge-timestamp reference model.
module tb_tt_um_clk_ratio_meter;

    localparam int CNT_W  = 8;
    localparam int LOCK_N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             sig_in;
    logic [CNT_W-1:0] period, high_time;
    logic [2:0]       ratio_code;
    logic             valid, locked, overflow;

    tt_um_clk_ratio_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .period     (period),
        .high_time  (high_time),
        .ratio_code (ratio_code),
        .valid      (valid),
        .locked     (locked),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: samples of sig_in per clk edge, rise/fall events as edge timestamps.
    int samp[$];
    int edge_no;
    bit armed;
    int last_rise, m_high, lock_cnt;
    int exp_period, exp_high, exp_code, exp_valid, exp_locked, exp_ovf;

    function automatic int s(input int k);
        if (samp.size() > k) return samp[samp.size()-1-k];
        return 0;
    endfunction

    function automatic int ratio_of(input int p, input int h);
        for (int n = 1; n <= 6; n++) begin
            if (p == (1 << n) && 2 * h == p) return n;
        end
        return 0;
    endfunction

    task automatic model_reset();
        samp.delete();
        armed = 0; last_rise = 0; m_high = 0; lock_cnt = 0;
        exp_period = 0; exp_high = 0; exp_code = 0;
        exp_valid = 0; exp_locked = 0; exp_ovf = 0;
    endtask

    task automatic model_edge(input logic v);
        bit r, f;
        int code;
        samp.push_back(int'(v));
        if (samp.size() > 8) void'(samp.pop_front());
        edge_no++;
        exp_valid = 0;
        r = (s(2) == 1) && (s(3) == 0);
        f = (s(2) == 0) && (s(3) == 1);
        if (r) begin
            if (armed) begin
                code = ratio_of(edge_no - last_rise, m_high);
                if (code == 0)             lock_cnt = 0;
                else if (code == exp_code) lock_cnt = (lock_cnt + 1 > LOCK_N) ? LOCK_N : lock_cnt + 1;
                else                       lock_cnt = 1;
                exp_period = edge_no - last_rise;
                exp_high   = m_high;
                exp_code   = code;
                exp_locked = (lock_cnt == LOCK_N);
                exp_ovf    = 0;
                exp_valid  = 1;
            end
            armed     = 1;
            last_rise = edge_no;
            m_high    = 0;
        end else if (armed) begin
            if (f) m_high = edge_no - last_rise;
            // Longest reportable period is 2^CNT_W-2; no rise by then means overflow.
            if (edge_no - last_rise == (1 << CNT_W) - 2) begin
                exp_ovf    = 1;
                exp_locked = 0;
                lock_cnt   = 0;
                armed      = 0;
            end
        end
    endtask

    task automatic check_all();
        check_val("valid",      32'(valid),      32'(exp_valid));
        check_val("period",     32'(period),     32'(exp_period));
        check_val("high_time",  32'(high_time),  32'(exp_high));
        check_val("ratio_code", 32'(ratio_code), 32'(exp_code));
        check_val("locked",     32'(locked),     32'(exp_locked));
        check_val("overflow",   32'(overflow),   32'(exp_ovf));
    endtask

    task automatic tick(input logic v);
        sig_in = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_all();
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        repeat (reps) begin
            repeat (hi) tick(1'b1);
            repeat (lo) tick(1'b0);
        end
    endtask

    // Called one time unit after an edge; asserts reset between edges.
    task automatic pulse_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(posedge clk);
        #4 reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        sig_in  = 1'b0;
        edge_no = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #3 reset = 1'b0;

        square(2, 2, 6);
        square(4, 4, 6);
        square(8, 8, 6);
        square(1, 1, 6);
        square(3, 3, 4);
        square(5, 3, 4);
        repeat (300) tick(1'b0);
        square(1, 1, 5);
        square(2, 2, 6);
        tick(1'b1);
        pulse_reset();
        square(2, 2, 5);

        repeat (30) begin
            int sel, n;
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                n = $urandom_range(1, 6);
                square(1 << (n - 1), 1 << (n - 1), $urandom_range(2, 7));
            end else if (sel == 6) begin
                square($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(2, 5));
            end else if (sel == 7) begin
                repeat ($urandom_range(200, 300)) tick(1'b0);
            end else if (sel == 8) begin
                tick(1'($urandom_range(0, 1)));
                pulse_reset();
            end else begin
                repeat ($urandom_range(100, 280)) tick(1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_clk_ratio_meter.md
# tt_um_clk_ratio_meter

Measures an incoming square wave, such as a divided clock from the cascaded divider, against the system clock. It reports period, high time and a decoded power-of-two divide ratio, plus a lock flag after repeated matching measurements. It sits on the receiving end of the divider chain as a built-in checker and frequency meter, and also accepts fully asynchronous inputs.

## Interface
- CNT_W, 8: width of period/high-time counters and outputs
- LOCK_N, 4: consecutive equal nonzero ratio codes required to assert locked (1..15)

- clk  input  1  system clock, all logic rising-edge
- reset  input  1  reset, asynchronous, active-high; clock clk
- sig_in  input  1  measured signal, may be asynchronous to clk
- period  output  CNT_W  clk cycles between last two rising edges of sig_in
- high_time  output  CNT_W  clk cycles sig_in was high in that period
- ratio_code  output  3  1..6 = divide-by 2,4,8,16,32,64; 0 = not a clean power-of-two square wave
- valid  output  1  one-cycle pulse, new measurement on period/high_time/ratio_code
- locked  output  1  LOCK_N consecutive measurements with same nonzero ratio_code
- overflow  output  1  sticky: counter saturated with no rising edge

## Operation
- Input path: 2-flop synchronizer (s1, s2), plus delay flop s3. rise = s2 & ~s3, fall = ~s2 & s3.
- FSM states: IDLE, MEASURE, STALL.
  - IDLE: wait for rise. On rise, clear counters and go to MEASURE. No valid. Falls are ignored.
  - MEASURE: cnt increments every cycle. On fall, latch hcnt = cycles since last rise.
    - On rise: period<=cnt, high_time<=hcnt, compute ratio_code, pulse valid, restart counting.
    - Period is defined as the distance in cycles between consecutive rise pulses. Example: pulses at cycles 10 and 14 give period=4.
  - In MEASURE, if cnt reaches 2^CNT_W-1 without a rise: overflow<=1, locked<=0, lock count cleared, go to STALL.
  - STALL: the next rise is treated as a first edge. Clear counters, go to MEASURE, no valid.
- ratio_code is nonzero only when both hold:
  - period = 2^n for n in 1..6, representable in CNT_W;
  - high_time = period/2.
  - If both hold, ratio_code = n; otherwise 0.
- Lock logic, evaluated on each valid:
  - If code ≠ 0 and code = previous code: lock count = min(count+1, LOCK_N).
  - If code ≠ 0 and differs from previous: lock count = 1.
  - If code = 0: lock count = 0.
  - locked = (lock count == LOCK_N), updated in the same cycle as valid.
- overflow clears on the first valid after STALL.
- period, high_time and ratio_code hold their values between valid pulses.

## Timing
- Reset values: period=0, high_time=0, ratio_code=0, valid=0, locked=0, overflow=0. s1/s2/s3=0, state IDLE, counters 0.
- Reset is asynchronous. Assertion mid-measurement clears everything immediately and aborts the measurement in progress.
- After reset release with sig_in already high, the synchronizer produces a rise. This is the first edge: IDLE→MEASURE, no valid.
- Latency: if sig_in is first sampled high at clk edge k, valid and the new outputs are visible after edge k+2.
- locked and overflow update in the same cycle as the valid pulse or the saturation event.
- Minimum measurable period is 2 cycles (sig_in = clk/2, synchronous). Narrower or asynchronous pulses may be missed by the synchronizer; no error is flagged.
- Maximum period is 2^CNT_W-2. Reaching 2^CNT_W-1 is an overflow.
- A rise in the same cycle as saturation takes priority: normal measurement, no overflow.

## Test plan
- sig_in = clk/4 (2 high, 2 low), LOCK_N=4 → no valid on first rise. Subsequent valids give period=4, high_time=2, ratio_code=2. locked=1 on the 4th valid.
- sig_in = clk/16 from divider → period=16, high_time=8, ratio_code=4. Locks after 4 valids. clk/2 input → period=2, high_time=1, code=1.
- 3 high / 3 low wave → period=6, high_time=3, ratio_code=0, locked stays 0. 5 high / 3 low → period=8, code=0.
- sig_in held low 300 cycles, CNT_W=8 → overflow=1 when cnt hits 255, locked=0, no valid. Then clk/2 input → first rise gives no valid; second rise gives valid, period=2, code=1, overflow=0.
- Locked on clk/4, then switch to clk/8 → first period-8 valid gives code=3 and locked=0 in the same cycle. Re-locks on the 4th period-8 valid.
- reset pulsed mid-period while locked → all outputs 0 immediately. After release, first rise gives no valid; second rise gives a correct measurement.
